// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: monitor FSM states, default width and maximal-length period.
// Used by the period monitor RTL and by lfsr benches.
package lfsr_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int unsigned MAXLEN_PERIOD = (32'd1 << DEFAULT_WIDTH) - 32'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/lfsr_period_monitor_if.sv
// Sample/control/result bundle of the LFSR period monitor.
// master drives start and samples; slave is the monitor producing results.
interface lfsr_period_monitor_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH + 1,
  parameter int RUN_W = 8
);

  logic             start;
  logic [WIDTH-1:0] state_in;
  logic             valid_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] ones_count;
  logic [RUN_W-1:0] max_run;
  logic             timeout;
  logic             zero_state;

  modport master (
    output start, state_in, valid_in,
    input  busy, done, period, ones_count, max_run, timeout, zero_state
  );

  modport slave (
    input  start, state_in, valid_in,
    output busy, done, period, ones_count, max_run, timeout, zero_state
  );

endinterface

// File: rtl/lfsr_period_monitor_run_tracker.sv
// Tracks current and longest run of identical bits, saturating at 2^RUN_W-1.
// Updates on the edge where init or en is high; init has priority.
module lfsr_period_monitor_run_tracker #(
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             en,
  input  logic             init,
  output logic [RUN_W-1:0] best_run
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             last_q, last_d;
  logic [RUN_W-1:0] cur_run_q, cur_run_d;
  logic [RUN_W-1:0] best_run_q, best_run_d;

  always_comb begin
    last_d     = last_q;
    cur_run_d  = cur_run_q;
    best_run_d = best_run_q;
    if (init) begin
      last_d     = bit_in;
      cur_run_d  = RUN_ONE;
      best_run_d = RUN_ONE;
    end else if (en) begin
      if (bit_in == last_q) begin
        cur_run_d = (cur_run_q == RUN_MAX) ? cur_run_q : cur_run_q + RUN_ONE;
      end else begin
        cur_run_d = RUN_ONE;
      end
      if (cur_run_d > best_run_q) begin
        best_run_d = cur_run_d;
      end
      last_d = bit_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b0;
      cur_run_q  <= '0;
      best_run_q <= '0;
    end else begin
      last_q     <= last_d;
      cur_run_q  <= cur_run_d;
      best_run_q <= best_run_d;
    end
  end

  assign best_run = best_run_q;

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures LFSR period, bit-0 ones count and longest bit-0 run from a reference sample.
// done pulses the cycle after the edge that samples the repeat; valid_in=0 stalls without effect.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = WIDTH + 1,
  parameter int RUN_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  lfsr_period_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(64'd1 << WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] ones_count_q, ones_count_d;
  logic [RUN_W-1:0] max_run_q, max_run_d;
  logic             timeout_q, timeout_d;
  logic             zero_state_q, zero_state_d;
  logic             done_q, done_d;
  logic             trk_init, trk_en;
  logic [RUN_W-1:0] best_run;

  lfsr_period_monitor_run_tracker #(.RUN_W(RUN_W)) u_run_tracker (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (mon.state_in[0]),
    .en       (trk_en),
    .init     (trk_init),
    .best_run (best_run)
  );

  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    cnt_d        = cnt_q;
    ones_d       = ones_q;
    period_d     = period_q;
    ones_count_d = ones_count_q;
    max_run_d    = max_run_q;
    timeout_d    = timeout_q;
    zero_state_d = zero_state_q;
    done_d       = 1'b0;
    trk_init     = 1'b0;
    trk_en       = 1'b0;
    cnt_n        = cnt_q + CNT_ONE;
    case (state_q)
      IDLE: begin
        // Previous results stay visible until the next measurement completes.
        if (mon.start) begin
          state_d      = ARM;
          timeout_d    = 1'b0;
          zero_state_d = 1'b0;
        end
      end
      ARM: begin
        if (mon.valid_in) begin
          ref_d        = mon.state_in;
          cnt_d        = '0;
          ones_d       = CNT_W'(mon.state_in[0]);
          zero_state_d = (mon.state_in == '0);
          trk_init     = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (mon.valid_in) begin
          if (mon.state_in == ref_q) begin
            period_d     = cnt_n;
            ones_count_d = ones_q;
            max_run_d    = best_run;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else if (cnt_n == CNT_LIMIT) begin
            timeout_d    = 1'b1;
            period_d     = '0;
            ones_count_d = ones_q;
            max_run_d    = best_run;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else begin
            // The repeat sample never reaches the counters or the run tracker.
            cnt_d  = cnt_n;
            ones_d = ones_q + CNT_W'(mon.state_in[0]);
            trk_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ref_q        <= '0;
      cnt_q        <= '0;
      ones_q       <= '0;
      period_q     <= '0;
      ones_count_q <= '0;
      max_run_q    <= '0;
      timeout_q    <= 1'b0;
      zero_state_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      cnt_q        <= cnt_d;
      ones_q       <= ones_d;
      period_q     <= period_d;
      ones_count_q <= ones_count_d;
      max_run_q    <= max_run_d;
      timeout_q    <= timeout_d;
      zero_state_q <= zero_state_d;
      done_q       <= done_d;
    end
  end

  assign mon.busy       = (state_q != IDLE);
  assign mon.done       = done_q;
  assign mon.period     = period_q;
  assign mon.ones_count = ones_count_q;
  assign mon.max_run    = max_run_q;
  assign mon.timeout    = timeout_q;
  assign mon.zero_state = zero_state_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Scoreboard bench for lfsr_period_monitor: directed sequences push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_lfsr_period_monitor;

  typedef struct {
    longint period;
    longint ones;
    longint run_lo;
    longint run_hi;
    longint timeout;
    longint zero;
    int     done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_period_monitor_if #(.WIDTH(16)) m16 ();
  lfsr_period_monitor_if #(.WIDTH(8))  m8 ();

  lfsr_period_monitor #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .mon   (m16)
  );

  // Narrow instance so the timeout/saturation case fits in a short run.
  lfsr_period_monitor #(.WIDTH(8)) u_dut_w8 (
    .clk   (clk),
    .reset (reset),
    .mon   (m8)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic compare_res(input string tag, input exp_t e, input longint per, input longint ones,
                             input longint run, input longint to, input longint zs, input longint busy);
    check({tag, " period"}, per, e.period);
    check({tag, " ones_count"}, ones, e.ones);
    check_range({tag, " max_run"}, run, e.run_lo, e.run_hi);
    check({tag, " timeout"}, to, e.timeout);
    check({tag, " zero_state"}, zs, e.zero);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " done cycle"}, cyc, e.done_cyc);
  endtask

  always @(negedge clk) begin
    if (reset && m16.done) begin
      check("dut16 done has pending result", longint'(q16.size() > 0), 1);
      if (q16.size() > 0)
        compare_res("dut16", q16.pop_front(), m16.period, m16.ones_count, m16.max_run,
                    m16.timeout, m16.zero_state, m16.busy);
    end
    if (reset && m8.done) begin
      check("dut8 done has pending result", longint'(q8.size() > 0), 1);
      if (q8.size() > 0)
        compare_res("dut8", q8.pop_front(), m8.period, m8.ones_count, m8.max_run,
                    m8.timeout, m8.zero_state, m8.busy);
    end
  end

  function automatic exp_t mk(input longint per, input longint ones, input longint lo,
                              input longint hi, input longint to, input longint zs);
    exp_t e;
    e.period = per; e.ones = ones; e.run_lo = lo; e.run_hi = hi;
    e.timeout = to; e.zero = zs; e.done_cyc = 0;
    return e;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic step16(input logic v, input logic [15:0] d);
    m16.valid_in = v;
    m16.state_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic v, input logic [7:0] d);
    m8.valid_in = v;
    m8.state_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic start16();
    m16.start    = 1'b1;
    m16.valid_in = 1'b0;
    @(posedge clk);
    #1;
    m16.start = 1'b0;
    check("busy after start", m16.busy, 1);
  endtask

  // Samples a..d (n of them, last one is the repeat) with gap idle cycles between.
  task automatic meas16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input int n, input int gap, input exp_t e);
    logic [15:0] s [4];
    exp_t        x;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    start16();
    for (int i = 0; i < n; i++) begin
      step16(1'b1, s[i]);
      if (i < n - 1) repeat (gap) step16(1'b0, 16'h0);
    end
    x = e;
    x.done_cyc = cyc;
    q16.push_back(x);
  endtask

  initial begin
    logic [15:0] s;
    exp_t        x;
    m16.start = 1'b0; m16.valid_in = 1'b0; m16.state_in = '0;
    m8.start  = 1'b0; m8.valid_in  = 1'b0; m8.state_in  = '0;
    repeat (2) @(negedge clk);
    check("reset busy", m16.busy, 0);
    check("reset done", m16.done, 0);
    check("reset period", m16.period, 0);
    check("reset ones_count", m16.ones_count, 0);
    check("reset max_run", m16.max_run, 0);
    check("reset timeout", m16.timeout, 0);
    check("reset zero_state", m16.zero_state, 0);
    check("reset w8 busy", m8.busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step16(1'b0, 16'h0);

    // Back-to-back: each start lands in the previous measurement's done cycle.
    meas16(16'h0001, 16'h0002, 16'h0003, 16'h0001, 4, 0, mk(3, 2, 1, 1, 0, 0));
    meas16(16'h0001, 16'h0002, 16'h0003, 16'h0001, 4, 5, mk(3, 2, 1, 1, 0, 0));
    meas16(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 0, mk(1, 0, 1, 1, 0, 1));
    step16(1'b0, 16'h0);

    // Timeout with saturated run on the 8-bit instance.
    m8.start = 1'b1;
    step8(1'b0, 8'h0);
    m8.start = 1'b0;
    step8(1'b1, 8'h34);
    repeat (256) step8(1'b1, 8'h00);
    x = mk(0, 0, 255, 255, 1, 0);
    x.done_cyc = cyc;
    q8.push_back(x);
    step8(1'b0, 8'h0);

    // start mid-RUN is ignored.
    start16();
    step16(1'b1, 16'h0001);
    step16(1'b1, 16'h0002);
    m16.start = 1'b1;
    step16(1'b1, 16'h0003);
    m16.start = 1'b0;
    step16(1'b1, 16'h0001);
    x = mk(3, 2, 1, 1, 0, 0);
    x.done_cyc = cyc;
    q16.push_back(x);
    step16(1'b0, 16'h0);

    // Reset mid-RUN clears outputs immediately and produces no done.
    start16();
    step16(1'b1, 16'h0003);
    step16(1'b1, 16'h0005);
    m16.valid_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrun reset busy", m16.busy, 0);
    check("midrun reset done", m16.done, 0);
    check("midrun reset period", m16.period, 0);
    check("midrun reset ones_count", m16.ones_count, 0);
    check("midrun reset max_run", m16.max_run, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) step16(1'b0, 16'h0);
    meas16(16'h0003, 16'h0005, 16'h0002, 16'h0003, 4, 0, mk(3, 2, 2, 2, 0, 0));
    step16(1'b0, 16'h0);

    // Full maximal-length sequence from seed 0xACE1.
    start16();
    s = 16'hACE1;
    for (int i = 0; i < 65535; i++) begin
      step16(1'b1, s);
      s = lfsr_next(s);
    end
    step16(1'b1, s);
    x = mk(65535, 32768, 15, 16, 0, 0);
    x.done_cyc = cyc;
    q16.push_back(x);
    step16(1'b0, 16'h0);

    for (int i = 0; i < 8 && (q16.size() > 0 || q8.size() > 0); i++) @(negedge clk);
    check("dut16 all results seen", q16.size(), 0);
    check("dut8 all results seen", q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
Name: lfsr_period_monitor

Overview:
- Downstream consumer of the team's 16-bit `lfsr` block. It samples the LFSR `state` bus and measures the sequence period, the bit-0 ones count and the longest bit-0 run.
- Turns "does this seed give a maximal-length sequence" into a self-checking hardware result.
- Sits beside the lfsr in benches and in the on-chip RNG health path.

Parameters:
- WIDTH, 16, width of the observed state bus.
- CNT_W, WIDTH+1, width of the period and ones counters; must hold 2^WIDTH.
- RUN_W, 8, width of the longest-run counter; the counter saturates at 2^RUN_W-1.

Ports:
- clk  input  1  rising-edge clock, same clock as the lfsr.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- start  input  1  one-cycle request to begin a measurement.
- state_in  input  WIDTH  LFSR state being observed.
- valid_in  input  1  state_in holds a new sample this cycle.
- busy  output  1  a measurement is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- period  output  CNT_W  samples from the reference sample to its first repeat; 0 on timeout.
- ones_count  output  CNT_W  number of samples in the period with state_in[0]=1.
- max_run  output  RUN_W  longest run of identical state_in[0] values within the period.
- timeout  output  1  the reference sample never repeated within 2^WIDTH samples.
- zero_state  output  1  the reference sample was all-zero (LFSR lock-up state).

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. busy, done, period, ones_count, max_run, timeout and zero_state are all 0. All internal registers are 0.
- FSM states: IDLE, ARM, RUN.
- IDLE:
  - start=1 goes to ARM next cycle with busy=1.
  - On leaving IDLE, timeout, zero_state and done clear; period, ones_count and max_run keep their old values until the new measurement completes.
- ARM:
  - Waits for valid_in=1.
  - On that edge: ref<=state_in, cnt<=0, ones<=state_in[0], last<=state_in[0], cur_run<=1, best_run<=1, zero_state<=(state_in==0).
  - Goes to RUN.
- RUN, on each valid_in=1 sample:
  - cnt_n = cnt+1.
  - If state_in==ref: period<=cnt_n, ones_count<=ones, max_run<=best_run, then IDLE. done=1 for exactly one cycle after that edge; busy falls in the same cycle.
  - Else if cnt_n==2^WIDTH: timeout<=1, period<=0, ones_count<=ones, max_run<=best_run, then IDLE with the same done pulse.
  - Else: cnt<=cnt_n and ones<=ones+state_in[0]. cur_run<=(state_in[0]==last)?cur_run+1:1, saturating at 2^RUN_W-1. best_run<=max(best_run, new cur_run). last<=state_in[0].
- The repeat sample is never counted into ones or runs. Samples counted are s0..s(P-1).
- Runs are counted linearly from s0, not cyclically across the wrap.
- valid_in=0 stalls every state; a stall never changes any result.
- start while busy is ignored. start in the same cycle as done is honoured: IDLE is re-entered and ARM follows next cycle.
- Latency:
  - The result appears one clock after the edge that samples the repeat.
  - For valid_in held high and a period of P, done occurs P+1 cycles after the ARM capture edge.
- Reset mid-run aborts silently: no done pulse, and outputs return to their reset values.

Decomposition:
- A shared package `lfsr_pkg` holds the FSM state enum (IDLE/ARM/RUN), the default WIDTH, and the `MAXLEN_PERIOD = 2^WIDTH-1` constant, also used by the lfsr bench.
- One natural sub-module, `run_tracker`: holds last, cur_run and best_run with saturation. Inputs are bit, sample enable and init.
- The period and ones counters stay in the top module.

Test Plan:
1. Cycle 0x0001, 0x0002, 0x0003, 0x0001 with valid_in high every cycle -> period=3, ones_count=2, max_run=1, timeout=0, zero_state=0. done pulses one cycle after the repeat edge.
2. Same sequence with valid_in low for 5 cycles between samples -> identical results; done one cycle after the repeat sample edge.
3. Constant 0x0000 -> period=1, ones_count=0, max_run=1, zero_state=1.
4. Reference 0x1234, then constant 0x0000 -> after 65536 non-matching samples: timeout=1, period=0, max_run=255 (saturated).
5. Drive from the team's 16-bit maximal-length lfsr seeded 0xACE1 -> period=65535, ones_count=32768, timeout=0, 15<=max_run<=16.
6. Pulse start again mid-RUN -> ignored and results unchanged. Drop reset mid-RUN -> outputs zero at once and no done pulse; the next start then measures correctly.
